multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM that sequences the existing datapath blocks (ALU, ALU_ctrl, registers,

---
 rtl/multicycle_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_ctrl_decode.sv | 76 +++++++
 rtl/multicycle_ctrl.sv | 124 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: state encodings, opcodes,
// datapath mux/ALU codes and the bundled control-word type.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ERROR     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational Moore decode of controller state (plus zero/mem_ready) into
// the datapath control word.
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   zero,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            S_DECODE: begin
                // branch target is precomputed into ALUOut here
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCSRC_BRANCH;
                ctrl.pc_en     = zero;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_en     = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: state register, memory wait/timeout counter,
// sticky trap flags and retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic             bus_error,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timed_out;
    ctrl_t             ctrl;

    ctrl_decode u_decode (
        .state     (state_q),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign timed_out = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES));

    // side-effecting strobes are masked while reset is held so a reset mid-op aborts cleanly
    assign pc_en      = rst & ctrl.pc_en;
    assign ir_write   = rst & ctrl.ir_write;
    assign mem_read   = rst & ctrl.mem_read;
    assign mem_write  = rst & ctrl.mem_write;
    assign reg_write  = rst & ctrl.reg_write;
    assign i_or_d     = ctrl.i_or_d;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign pc_source  = ctrl.pc_source;
    assign state      = state_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_cnt  <= '0;
            retired   <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            // counter is zero on every cycle except a stalled memory cycle,
            // which gives "cleared on entry" for free
            wait_cnt <= '0;
            if (is_mem_state(state_q) && !mem_ready) begin
                if (timed_out) begin
                    state_q   <= S_ERROR;
                    bus_error <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end else begin
                case (state_q)
                    S_FETCH: state_q <= S_DECODE;
                    S_DECODE: begin
                        case (opcode)
                            OP_RTYPE:     state_q <= S_R_EXEC;
                            OP_LW, OP_SW: state_q <= S_MEM_ADDR;
                            OP_BEQ:       state_q <= S_BRANCH;
                            OP_J:         state_q <= S_JUMP;
                            OP_ADDI:      state_q <= S_ADDI_EXEC;
                            default: begin
                                state_q <= S_ERROR;
                                illegal <= 1'b1;
                            end
                        endcase
                    end
                    S_MEM_ADDR: begin
                        if (opcode == OP_LW) begin
                            state_q <= S_MEM_RD;
                        end else if (opcode == OP_SW) begin
                            state_q <= S_MEM_WR;
                        end else begin
                            state_q <= S_ERROR;
                            illegal <= 1'b1;
                        end
                    end
                    S_MEM_RD:    state_q <= S_MEM_WB;
                    S_R_EXEC:    state_q <= S_R_WB;
                    S_ADDI_EXEC: state_q <= S_ADDI_WB;
                    S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                        state_q <= S_FETCH;
                        retired <= retired + 1'b1;
                    end
                    S_ERROR: state_q <= S_ERROR;
                    default: begin
                        state_q <= S_ERROR;
                        illegal <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with hand-computed state sequences and
// control values; built with TIMEOUT_CYCLES=3 to reach the timeout boundary.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        illegal, bus_error;
    logic [31:0] retired;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.TIMEOUT_CYCLES(3), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .state      (state),
        .illegal    (illegal),
        .bus_error  (bus_error),
        .retired    (retired)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic at_state(input string tag, input logic [3:0] exp);
        #1;
        check(tag, 32'(state), 32'(exp));
    endtask

    function automatic logic [31:0] strobes();
        return 32'({pc_en, ir_write, mem_read, mem_write, reg_write});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; opcode = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        next_cycle; next_cycle;
        at_state("rst_state", 4'd0);
        check("rst_retired", retired, 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_bus_error", 32'(bus_error), 0);
        check("rst_strobes", strobes(), 0);
        rst = 1'b1;
        #1;
        check("fetch_strobes", strobes(), 32'b11100);

        // addi: 0,1,10,11,0
        opcode = 6'b001000;
        at_state("addi_s0", 4'd0);
        check("addi_srcb_fetch", 32'(alu_src_b), 1);
        next_cycle; at_state("addi_s1", 4'd1);
        check("addi_srcb_decode", 32'(alu_src_b), 3);
        next_cycle; at_state("addi_s2", 4'd10);
        check("addi_srcb_exec", 32'(alu_src_b), 2);
        check("addi_regw_exec", 32'(reg_write), 0);
        next_cycle; at_state("addi_s3", 4'd11);
        check("addi_regw_wb", 32'(reg_write), 1);
        check("addi_retired_pre", retired, 0);
        next_cycle; at_state("addi_s4", 4'd0);
        check("addi_retired", retired, 1);

        // lw with three wait cycles in MEM_RD: MEM_WB lands on cycle 8
        opcode = 6'b100011;
        next_cycle; at_state("lw_s1", 4'd1);
        next_cycle; mem_ready = 1'b0; at_state("lw_s2", 4'd2);
        for (int i = 0; i < 4; i++) begin
            next_cycle;
            if (i == 3) mem_ready = 1'b1;
            at_state("lw_memrd", 4'd3);
            check("lw_mem_read", 32'(mem_read), 1);
            check("lw_i_or_d", 32'(i_or_d), 1);
        end
        next_cycle; at_state("lw_wb_cycle8", 4'd4);
        check("lw_mem_to_reg", 32'(mem_to_reg), 1);
        check("lw_reg_write", 32'(reg_write), 1);
        next_cycle; at_state("lw_done", 4'd0);
        check("lw_retired", retired, 2);

        // sw
        opcode = 6'b101011;
        next_cycle; at_state("sw_s1", 4'd1);
        next_cycle; at_state("sw_s2", 4'd2);
        next_cycle; at_state("sw_memwr", 4'd5);
        check("sw_strobes", strobes(), 32'b00010);
        check("sw_i_or_d", 32'(i_or_d), 1);
        next_cycle; at_state("sw_done", 4'd0);
        check("sw_retired", retired, 3);

        // beq taken / not taken
        opcode = 6'b000100; zero = 1'b1;
        next_cycle; at_state("beq1_s1", 4'd1);
        next_cycle; at_state("beq1_br", 4'd8);
        check("beq1_pc_en", 32'(pc_en), 1);
        check("beq1_pc_source", 32'(pc_source), 1);
        check("beq1_alu_op", 32'(alu_op), 1);
        next_cycle; at_state("beq1_done", 4'd0);
        check("beq1_retired", retired, 4);
        zero = 1'b0;
        next_cycle; at_state("beq0_s1", 4'd1);
        next_cycle; at_state("beq0_br", 4'd8);
        check("beq0_pc_en", 32'(pc_en), 0);
        next_cycle; at_state("beq0_done", 4'd0);
        check("beq0_retired", retired, 5);

        // j
        opcode = 6'b000010;
        next_cycle; at_state("j_s1", 4'd1);
        next_cycle; at_state("j_jump", 4'd9);
        check("j_pc_en", 32'(pc_en), 1);
        check("j_pc_source", 32'(pc_source), 2);
        next_cycle; at_state("j_done", 4'd0);
        check("j_retired", retired, 6);

        // R-type
        opcode = 6'b000000;
        next_cycle; at_state("r_s1", 4'd1);
        next_cycle; at_state("r_exec", 4'd6);
        check("r_alu_op", 32'(alu_op), 2);
        check("r_alu_src_a", 32'(alu_src_a), 1);
        next_cycle; at_state("r_wb", 4'd7);
        check("r_reg_dst", 32'(reg_dst), 1);
        check("r_reg_write", 32'(reg_write), 1);
        next_cycle; at_state("r_done", 4'd0);
        check("r_retired", retired, 7);

        // illegal opcode traps and holds until reset
        opcode = 6'b111111;
        next_cycle; at_state("ill_s1", 4'd1);
        check("ill_flag_pre", 32'(illegal), 0);
        for (int i = 0; i < 10; i++) begin
            next_cycle; at_state("ill_error", 4'd15);
            check("ill_strobes", strobes(), 0);
        end
        check("ill_flag", 32'(illegal), 1);
        check("ill_retired", retired, 7);
        rst = 1'b0;
        next_cycle; rst = 1'b1;
        at_state("ill_reset", 4'd0);
        check("ill_cleared", 32'(illegal), 0);
        check("ill_retired_rst", retired, 0);

        // timeout in FETCH: four stalled cycles then ERROR
        opcode = 6'b001000; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            at_state("to_fetch", 4'd0);
            check("to_ir_write", 32'(ir_write), 0);
            next_cycle;
        end
        at_state("to_error", 4'd15);
        check("to_bus_error", 32'(bus_error), 1);
        rst = 1'b0;
        next_cycle; rst = 1'b1;

        // ready on the fourth cycle wins over the timeout
        for (int i = 0; i < 3; i++) begin
            at_state("rdy_fetch", 4'd0);
            next_cycle;
        end
        mem_ready = 1'b1;
        at_state("rdy_fetch4", 4'd0);
        check("rdy_ir_write", 32'(ir_write), 1);
        next_cycle; at_state("rdy_decode", 4'd1);
        check("rdy_bus_error", 32'(bus_error), 0);
        next_cycle; at_state("rdy_s2", 4'd10);
        next_cycle; at_state("rdy_s3", 4'd11);
        next_cycle; at_state("rdy_done", 4'd0);
        check("rdy_retired", retired, 1);

        // reset asserted mid-store aborts with no strobes
        opcode = 6'b101011;
        next_cycle; at_state("rw_s1", 4'd1);
        next_cycle; mem_ready = 1'b0; at_state("rw_s2", 4'd2);
        next_cycle; at_state("rw_memwr", 4'd5);
        check("rw_mem_write", 32'(mem_write), 1);
        rst = 1'b0;
        #1;
        check("rw_strobes_rst", strobes(), 0);
        next_cycle; rst = 1'b1;
        at_state("rw_fetch", 4'd0);
        check("rw_retired", retired, 0);
        check("rw_mem_write_after", 32'(mem_write), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
